dfii_csr_responder: RTL and testbench
=====================================

# dfii_csr_responder

Wishbone classic responder implementing the DFII software-control register bank: word-addressed CSRs at a configurable base (0x9000 byte / 0x2400 word by default) let a bus master drive CKE/ODT/RESET_N, stage a DRAM command with address and bank, and fire it as a single-cycle DFI phase-0 command. It sits between the SoC Wishbone interconnect and the DFI mux in front of the PHY. While the SEL bit is set, the downstream mux hands the DFI to the hardware controller.

## Interface
- `WB_ADR_WIDTH`, 30, Wishbone word-address width.
- `BASE_WORD`, 30'h2400, word address of register 0; must be 8-word aligned.
- `A_WIDTH`, 14, DRAM address width.
- `BA_WIDTH`, 3, bank address width.

- `clk` in 1: single clock; every output is registered on its rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `wb_adr` in WB_ADR_WIDTH: word address.
- `wb_dat_w` in 32: write data.
- `wb_dat_r` out 32: read data, valid while `wb_ack`=1.
- `wb_sel` in 4: byte enables.
- `wb_cyc`, `wb_stb`, `wb_we` in 1 each: classic bus cycle qualifiers.
- `wb_ack` out 1: transfer acknowledge.
- `dfi_cs_n`, `dfi_ras_n`, `dfi_cas_n`, `dfi_we_n` out 1 each: phase-0 command.
- `dfi_address` out A_WIDTH; `dfi_bank` out BA_WIDTH.
- `dfi_cke`, `dfi_odt`, `dfi_reset_n` out 1 each.
- `dfi_wrdata_en`, `dfi_rddata_en` out 1 each.
- `dfi_wrdata` out 32.
- `dfi_rddata` in 32; `dfi_rddata_valid` in 1.
- `hw_sel` out 1: 1 = hardware controller owns the DFI.

## Operation
- Register map, word offset from BASE_WORD:
  - 0 CONTROL: bit0 SEL, bit1 CKE, bit2 ODT, bit3 RESET_N.
  - 1 COMMAND: bit0 CS, bit1 WE, bit2 CAS, bit3 RAS, bit4 WRDATA, bit5 RDDATA.
  - 2 ISSUE: write-only; reads return 0.
  - 3 ADDRESS: A_WIDTH bits.
  - 4 BADDRESS: BA_WIDTH bits.
  - 5 WRDATA: 32 bits.
  - 6 RDDATA: read-only.
  - 7 STATUS: bit0 RD_CAPTURED, read-only.
- Decode: a register is hit when `wb_adr[WB_ADR_WIDTH-1:3]`==`BASE_WORD[WB_ADR_WIDTH-1:3]`. Out-of-range addresses are still acked; reads return 0 and writes are dropped.
- Writes honour `wb_sel` per byte lane. Bits beyond a register's width are ignored on write and read back as 0.
- Bus FSM has two states:
  - IDLE → ACK when `wb_cyc&wb_stb`. On that edge: the write is performed, or `wb_dat_r` is loaded; `wb_ack` goes to 1.
  - ACK → IDLE unconditionally; `wb_ack` goes to 0.
  - Minimum transaction is 2 cycles. A master holding `stb` high gets a new transaction every 2 cycles.
- ISSUE: a write with `wb_sel[0]=1`, `wb_dat_w[0]=1` and SEL=0 produces a one-cycle command pulse on the cycle after ack.
  - `dfi_cs_n`=~CS, `dfi_ras_n`=~RAS, `dfi_cas_n`=~CAS, `dfi_we_n`=~WE.
  - `dfi_wrdata_en`=WRDATA, `dfi_rddata_en`=RDDATA.
  - The issue also clears RD_CAPTURED.
  - When SEL=1, ISSUE writes are acked with no pulse.
- Idle DFI command is NOP: all four command lines 1, both enables 0.
- `dfi_address`, `dfi_bank` and `dfi_wrdata` continuously mirror ADDRESS, BADDRESS and WRDATA.
- `dfi_cke`, `dfi_odt`, `dfi_reset_n` and `hw_sel` continuously mirror their CONTROL bits.
- RDDATA capture: any cycle with `dfi_rddata_valid`=1 loads RDDATA and sets RD_CAPTURED. The last beat wins.

## Timing
- Reset values:
  - `wb_ack`=0, `wb_dat_r`=0.
  - All registers 0, so `dfi_reset_n`=0, `dfi_cke`=0, `dfi_odt`=0, `hw_sel`=0.
  - DFI command is NOP, `dfi_address`=0, `dfi_bank`=0, `dfi_wrdata`=0.
- Ack latency is 1 cycle after `cyc&stb` is sampled. A written register value is visible on the mirrored outputs in the same cycle `wb_ack`=1.
- Command pulse timing: the ack edge is N, the pulse is asserted at N+1 and returns to NOP at N+2. Exactly one pulse is produced per ISSUE write.
- Read of RDDATA in the same cycle as `dfi_rddata_valid` returns the old value; the new value is visible on the next read.
- Deasserting `cyc` or `stb` while in ACK does not extend or cancel the ack.
- Reset mid-transaction or mid-pulse: the FSM returns to IDLE and all outputs take reset values immediately (asynchronously). A pending pulse is lost.

## Test plan
- Reset → `dfi_reset_n`=0, `dfi_cke`=0, `wb_ack`=0, command NOP. Read of every offset 0–7 returns 0.
- Write CONTROL=0x0C, then 0x0E → `dfi_reset_n`=1, `dfi_odt`=1, and `dfi_cke`=1 during the second write's ack cycle. Reading CONTROL returns 0x0E.
- Mode-register set: ADDRESS=0x200, BADDRESS=2, COMMAND=0x0F, ISSUE=1 → exactly one cycle of cs/ras/cas/we_n = 0000 with `dfi_address`=0x200 and `dfi_bank`=2. Output is NOP before and after.
- ZQ calibration: ADDRESS=0x400, COMMAND=0x03, ISSUE=1 → one cycle with cs_n=0, we_n=0, ras_n=1, cas_n=1. Then with CONTROL=0x01, an ISSUE write produces no pulse and `hw_sel`=1.
- Read capture: COMMAND=0x25, ISSUE=1 → `dfi_rddata_en` pulses once. Then drive `dfi_rddata`=0xFACECA8C with valid for 1 cycle → RDDATA reads 0xFACECA8C and STATUS reads 1. The next ISSUE clears STATUS to 0.
- Byte enables and decode: write WRDATA=0xFFFFFFFF, then 0x12345678 with sel=0x3 → reads 0xFFFF5678. A write to word 0x2408 is acked, reads 0, and changes no register.

Source files
------------

// File: rtl/dfii_csr_responder.sv
// DFII software-control CSR bank on a Wishbone classic slave port.
// Lets a bus master drive CKE/ODT/RESET_N and fire single-cycle DFI phase-0 commands.
module dfii_csr_responder #(
  parameter int                      WB_ADR_WIDTH = 30,
  parameter logic [WB_ADR_WIDTH-1:0] BASE_WORD    = 30'h2400,
  parameter int                      A_WIDTH      = 14,
  parameter int                      BA_WIDTH     = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WB_ADR_WIDTH-1:0] wb_adr,
  input  logic [31:0]             wb_dat_w,
  output logic [31:0]             wb_dat_r,
  input  logic [3:0]              wb_sel,
  input  logic                    wb_cyc,
  input  logic                    wb_stb,
  input  logic                    wb_we,
  output logic                    wb_ack,
  output logic                    dfi_cs_n,
  output logic                    dfi_ras_n,
  output logic                    dfi_cas_n,
  output logic                    dfi_we_n,
  output logic [A_WIDTH-1:0]      dfi_address,
  output logic [BA_WIDTH-1:0]     dfi_bank,
  output logic                    dfi_cke,
  output logic                    dfi_odt,
  output logic                    dfi_reset_n,
  output logic                    dfi_wrdata_en,
  output logic                    dfi_rddata_en,
  output logic [31:0]             dfi_wrdata,
  input  logic [31:0]             dfi_rddata,
  input  logic                    dfi_rddata_valid,
  output logic                    hw_sel
);

  typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} state_t;

  localparam logic [2:0] OFF_CONTROL  = 3'd0;
  localparam logic [2:0] OFF_COMMAND  = 3'd1;
  localparam logic [2:0] OFF_ISSUE    = 3'd2;
  localparam logic [2:0] OFF_ADDRESS  = 3'd3;
  localparam logic [2:0] OFF_BADDRESS = 3'd4;
  localparam logic [2:0] OFF_WRDATA   = 3'd5;
  localparam logic [2:0] OFF_RDDATA   = 3'd6;
  localparam logic [2:0] OFF_STATUS   = 3'd7;

  function automatic logic [31:0] expand_sel(input logic [3:0] sel);
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{sel[i]}};
    end
    return mask;
  endfunction

  state_t               state_r;
  state_t               state_nxt_s;
  logic                 access_s;
  logic                 hit_s;
  logic                 wr_s;
  logic                 issue_s;
  logic [31:0]          wmask_s;
  logic [31:0]          rd_val_s;

  logic                 wb_ack_r;
  logic [31:0]          wb_dat_r_r;
  logic [3:0]           control_r;
  logic [5:0]           command_r;
  logic [A_WIDTH-1:0]   address_r;
  logic [BA_WIDTH-1:0]  baddress_r;
  logic [31:0]          wrdata_r;
  logic [31:0]          rddata_r;
  logic                 rd_captured_r;
  logic                 issue_pend_r;
  logic [3:0]           cmd_n_r;
  logic                 wrdata_en_r;
  logic                 rddata_en_r;

  assign hit_s   = (wb_adr[WB_ADR_WIDTH-1:3] == BASE_WORD[WB_ADR_WIDTH-1:3]);
  assign wr_s    = access_s & wb_we & hit_s;
  // An ISSUE write only fires while software (not the hardware controller) owns the DFI.
  assign issue_s = wr_s & (wb_adr[2:0] == OFF_ISSUE) & wb_sel[0] & wb_dat_w[0] & ~control_r[0];
  assign wmask_s = expand_sel(wb_sel);

  // Bus FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Bus FSM next-state logic.
  always_comb begin
    state_nxt_s = S_IDLE;
    case (state_r)
      S_IDLE:  state_nxt_s = (wb_cyc & wb_stb) ? S_ACK : S_IDLE;
      S_ACK:   state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Bus FSM output decode: a transfer is accepted on the IDLE->ACK edge.
  always_comb begin
    access_s = 1'b0;
    case (state_r)
      S_IDLE:  access_s = wb_cyc & wb_stb;
      S_ACK:   access_s = 1'b0;
      default: access_s = 1'b0;
    endcase
  end

  // Read multiplexer; unused register bits read as zero.
  always_comb begin
    rd_val_s = 32'd0;
    if (hit_s) begin
      case (wb_adr[2:0])
        OFF_CONTROL:  rd_val_s = {28'd0, control_r};
        OFF_COMMAND:  rd_val_s = {26'd0, command_r};
        OFF_ISSUE:    rd_val_s = 32'd0;
        OFF_ADDRESS:  rd_val_s = {{(32-A_WIDTH){1'b0}}, address_r};
        OFF_BADDRESS: rd_val_s = {{(32-BA_WIDTH){1'b0}}, baddress_r};
        OFF_WRDATA:   rd_val_s = wrdata_r;
        OFF_RDDATA:   rd_val_s = rddata_r;
        OFF_STATUS:   rd_val_s = {31'd0, rd_captured_r};
        default:      rd_val_s = 32'd0;
      endcase
    end else begin
      rd_val_s = 32'd0;
    end
  end

  // Bus response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack_r   <= 1'b0;
      wb_dat_r_r <= 32'd0;
    end else begin
      wb_ack_r <= (state_nxt_s == S_ACK);
      if (access_s) begin
        wb_dat_r_r <= wb_we ? 32'd0 : rd_val_s;
      end
    end
  end

  // Writable CSRs with per-byte-lane enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      control_r  <= 4'd0;
      command_r  <= 6'd0;
      address_r  <= '0;
      baddress_r <= '0;
      wrdata_r   <= 32'd0;
    end else if (wr_s) begin
      case (wb_adr[2:0])
        OFF_CONTROL:  control_r  <= (control_r & ~wmask_s[3:0]) | (wb_dat_w[3:0] & wmask_s[3:0]);
        OFF_COMMAND:  command_r  <= (command_r & ~wmask_s[5:0]) | (wb_dat_w[5:0] & wmask_s[5:0]);
        OFF_ADDRESS:  address_r  <= (address_r & ~wmask_s[A_WIDTH-1:0])
                                    | (wb_dat_w[A_WIDTH-1:0] & wmask_s[A_WIDTH-1:0]);
        OFF_BADDRESS: baddress_r <= (baddress_r & ~wmask_s[BA_WIDTH-1:0])
                                    | (wb_dat_w[BA_WIDTH-1:0] & wmask_s[BA_WIDTH-1:0]);
        OFF_WRDATA:   wrdata_r   <= (wrdata_r & ~wmask_s) | (wb_dat_w & wmask_s);
        default:      ;
      endcase
    end
  end

  // Read-data capture: a new beat outranks the clear from a simultaneous issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rddata_r      <= 32'd0;
      rd_captured_r <= 1'b0;
    end else if (dfi_rddata_valid) begin
      rddata_r      <= dfi_rddata;
      rd_captured_r <= 1'b1;
    end else if (issue_s) begin
      rd_captured_r <= 1'b0;
    end
  end

  // Command pulse: staged on the ack edge, driven for exactly one cycle after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_pend_r <= 1'b0;
      cmd_n_r      <= 4'hF;
      wrdata_en_r  <= 1'b0;
      rddata_en_r  <= 1'b0;
    end else begin
      issue_pend_r <= issue_s;
      if (issue_pend_r) begin
        cmd_n_r     <= ~{command_r[0], command_r[3], command_r[2], command_r[1]};
        wrdata_en_r <= command_r[4];
        rddata_en_r <= command_r[5];
      end else begin
        cmd_n_r     <= 4'hF;
        wrdata_en_r <= 1'b0;
        rddata_en_r <= 1'b0;
      end
    end
  end

  assign wb_ack        = wb_ack_r;
  assign wb_dat_r      = wb_dat_r_r;
  assign dfi_cs_n      = cmd_n_r[3];
  assign dfi_ras_n     = cmd_n_r[2];
  assign dfi_cas_n     = cmd_n_r[1];
  assign dfi_we_n      = cmd_n_r[0];
  assign dfi_wrdata_en = wrdata_en_r;
  assign dfi_rddata_en = rddata_en_r;
  assign dfi_address   = address_r;
  assign dfi_bank      = baddress_r;
  assign dfi_wrdata    = wrdata_r;
  assign hw_sel        = control_r[0];
  assign dfi_cke       = control_r[1];
  assign dfi_odt       = control_r[2];
  assign dfi_reset_n   = control_r[3];

endmodule

// File: tb/tb_dfii_csr_responder.sv
// Directed self-checking bench for dfii_csr_responder.
module tb_dfii_csr_responder;

  localparam logic [29:0] BASE = 30'h2400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [29:0] wb_adr = 30'd0;
  logic [31:0] wb_dat_w = 32'd0;
  logic [31:0] wb_dat_r;
  logic [3:0]  wb_sel = 4'd0;
  logic        wb_cyc = 1'b0;
  logic        wb_stb = 1'b0;
  logic        wb_we = 1'b0;
  logic        wb_ack;
  logic        dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n;
  logic [13:0] dfi_address;
  logic [2:0]  dfi_bank;
  logic        dfi_cke, dfi_odt, dfi_reset_n;
  logic        dfi_wrdata_en, dfi_rddata_en;
  logic [31:0] dfi_wrdata;
  logic [31:0] dfi_rddata = 32'd0;
  logic        dfi_rddata_valid = 1'b0;
  logic        hw_sel;

  int n_checks = 0;
  int n_pass = 0;

  wire [3:0] cmd_s = {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n};
  wire [1:0] en_s  = {dfi_wrdata_en, dfi_rddata_en};

  dfii_csr_responder dut (
    .clk(clk), .rst_n(rst_n),
    .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r), .wb_sel(wb_sel),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_ack(wb_ack),
    .dfi_cs_n(dfi_cs_n), .dfi_ras_n(dfi_ras_n), .dfi_cas_n(dfi_cas_n), .dfi_we_n(dfi_we_n),
    .dfi_address(dfi_address), .dfi_bank(dfi_bank),
    .dfi_cke(dfi_cke), .dfi_odt(dfi_odt), .dfi_reset_n(dfi_reset_n),
    .dfi_wrdata_en(dfi_wrdata_en), .dfi_rddata_en(dfi_rddata_en),
    .dfi_wrdata(dfi_wrdata), .dfi_rddata(dfi_rddata), .dfi_rddata_valid(dfi_rddata_valid),
    .hw_sel(hw_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One classic transfer; returns in the ack cycle with the read data.
  task automatic bus(input logic we, input logic [29:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, output logic [31:0] rd);
    int n;
    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
    wb_adr = adr; wb_dat_w = dat; wb_sel = sel;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!wb_ack && n < 8);
    check("ack", {31'd0, wb_ack}, 32'd1);
    rd = wb_dat_r;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] unused_rd;
    bus(1'b1, BASE + {27'd0, off}, dat, sel, unused_rd);
  endtask

  task automatic rd_chk(input string tag, input logic [29:0] adr, input logic [31:0] exp);
    logic [31:0] v;
    bus(1'b0, adr, 32'd0, 4'hF, v);
    check(tag, v, exp);
  endtask

  // Checks NOP in the ack cycle, the expected pulse next cycle, NOP after.
  task automatic pulse_chk(input string tag, input logic [3:0] cmd, input logic [1:0] en);
    check({tag, "_pre"}, {28'd0, cmd_s}, 32'hF);
    @(posedge clk); #1;
    check({tag, "_cmd"}, {28'd0, cmd_s}, {28'd0, cmd});
    check({tag, "_en"}, {30'd0, en_s}, {30'd0, en});
    @(posedge clk); #1;
    check({tag, "_post"}, {26'd0, en_s, cmd_s}, 32'h0F);
  endtask

  initial begin
    #12;
    check("rst_ack", {31'd0, wb_ack}, 32'd0);
    check("rst_dat_r", wb_dat_r, 32'd0);
    check("rst_pins", {28'd0, dfi_reset_n, dfi_cke, dfi_odt, hw_sel}, 32'd0);
    check("rst_cmd", {26'd0, en_s, cmd_s}, 32'h0F);
    check("rst_addr", {15'd0, dfi_bank, dfi_address}, 32'd0);
    check("rst_wrdata", dfi_wrdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_chk($sformatf("rst_reg%0d", i), BASE + 30'(i), 32'd0);
    end

    // Power-up control sequence.
    wr(3'd0, 32'h0000_000C, 4'hF);
    check("ctl_c", {29'd0, dfi_reset_n, dfi_odt, dfi_cke}, 32'h6);
    wr(3'd0, 32'h0000_000E, 4'hF);
    check("ctl_e", {29'd0, dfi_reset_n, dfi_odt, dfi_cke}, 32'h7);
    rd_chk("ctl_rd", BASE, 32'h0E);

    // Mode-register set.
    wr(3'd3, 32'h0000_0200, 4'hF);
    wr(3'd4, 32'h0000_0002, 4'hF);
    wr(3'd1, 32'h0000_000F, 4'hF);
    wr(3'd2, 32'h0000_0001, 4'hF);
    check("mrs_addr", {15'd0, dfi_bank, dfi_address}, {15'd0, 3'd2, 14'h200});
    pulse_chk("mrs", 4'b0000, 2'b00);

    // ZQ calibration, then the same with the hardware controller selected.
    wr(3'd3, 32'h0000_0400, 4'hF);
    wr(3'd1, 32'h0000_0003, 4'hF);
    wr(3'd2, 32'h0000_0001, 4'hF);
    pulse_chk("zq", 4'b0110, 2'b00);
    wr(3'd0, 32'h0000_0001, 4'hF);
    check("hw_sel", {31'd0, hw_sel}, 32'd1);
    wr(3'd2, 32'h0000_0001, 4'hF);
    @(posedge clk); #1;
    check("sel_nopulse1", {26'd0, en_s, cmd_s}, 32'h0F);
    @(posedge clk); #1;
    check("sel_nopulse2", {26'd0, en_s, cmd_s}, 32'h0F);
    wr(3'd0, 32'h0000_000E, 4'hF);

    // Read capture.
    wr(3'd1, 32'h0000_0025, 4'hF);
    wr(3'd2, 32'h0000_0001, 4'hF);
    pulse_chk("rdcmd", 4'b0101, 2'b01);
    rd_chk("status_pre", BASE + 30'd7, 32'd0);
    dfi_rddata = 32'hFACE_CA8C; dfi_rddata_valid = 1'b1;
    @(posedge clk); #1;
    dfi_rddata_valid = 1'b0; dfi_rddata = 32'd0;
    rd_chk("rddata", BASE + 30'd6, 32'hFACE_CA8C);
    rd_chk("status_set", BASE + 30'd7, 32'd1);
    wr(3'd2, 32'h0000_0001, 4'hF);
    rd_chk("status_clr", BASE + 30'd7, 32'd0);

    // Byte enables, width truncation and decode.
    wr(3'd5, 32'hFFFF_FFFF, 4'hF);
    check("wrdata_mirror", dfi_wrdata, 32'hFFFF_FFFF);
    wr(3'd5, 32'h1234_5678, 4'h3);
    rd_chk("wrdata_bytes", BASE + 30'd5, 32'hFFFF_5678);
    check("wrdata_mirror2", dfi_wrdata, 32'hFFFF_5678);
    wr(3'd4, 32'hFFFF_FFFF, 4'hF);
    rd_chk("bank_width", BASE + 30'd4, 32'h7);
    wr(3'd4, 32'h0000_0005, 4'h0);
    rd_chk("bank_nosel", BASE + 30'd4, 32'h7);
    begin
      logic [31:0] unused_rd;
      bus(1'b1, 30'h2408, 32'hFFFF_FFFF, 4'hF, unused_rd);
    end
    rd_chk("oor_rd", 30'h2408, 32'd0);
    rd_chk("oor_ctl", BASE, 32'h0E);
    rd_chk("oor_addr", BASE + 30'd3, 32'h400);
    rd_chk("oor_cmd", BASE + 30'd1, 32'h25);
    rd_chk("oor_wrdata", BASE + 30'd5, 32'hFFFF_5678);

    // Asynchronous reset during the ack cycle of an issue drops the pulse.
    wr(3'd2, 32'h0000_0001, 4'hF);
    rst_n = 1'b0;
    #1;
    check("arst_ack", {31'd0, wb_ack}, 32'd0);
    check("arst_pins", {28'd0, dfi_reset_n, dfi_cke, dfi_odt, hw_sel}, 32'd0);
    @(posedge clk); #1;
    check("arst_nopulse", {26'd0, en_s, cmd_s}, 32'h0F);
    rst_n = 1'b1;
    rd_chk("arst_ctl", BASE, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
